// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control and memory-wait freeze FSM for the 5-stage pipe.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       MemRead_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       PCSrc_E,
  input  logic       dmem_req_M,
  input  logic       dmem_ready,
  output logic       valid_PC,
  output logic       valid_FD,
  output logic       valid_DE,
  output logic       valid_EM,
  output logic       valid_MW,
  output logic       flush_FD,
  output logic       flush_DE,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_br_flushes,
  output logic [31:0] perf_mem_freeze
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             boot, stall_mem, lu;
  logic             freeze, win_br, win_lu;

  assign boot      = (state_q == BOOT);
  assign stall_mem = dmem_req_M && !dmem_ready;
  assign lu        = MemRead_E && (Rd_E != 5'd0) &&
                     ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign freeze    = (state_q == MEM_WAIT) ||
                     ((state_q == RUN) && stall_mem);
  assign win_br    = !boot && !freeze && PCSrc_E;
  assign win_lu    = !boot && !freeze && !PCSrc_E && lu;

  // M-stage result is younger, so it wins over W.
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (rst) begin
      if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
        ForwardA_E = 2'b10;
      else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
        ForwardA_E = 2'b01;
      if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
        ForwardB_E = 2'b10;
      else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
        ForwardB_E = 2'b01;
    end
  end

  always_comb begin
    valid_PC = 1'b1;
    valid_FD = 1'b1;
    valid_DE = 1'b1;
    valid_EM = 1'b1;
    valid_MW = 1'b1;
    flush_FD = 1'b0;
    flush_DE = 1'b0;
    unique case (1'b1)
      boot: begin
        {valid_PC, valid_FD, valid_DE} = 3'b000;
        {valid_EM, valid_MW} = 2'b00;
        {flush_FD, flush_DE} = 2'b11;
      end
      freeze: begin
        {valid_PC, valid_FD, valid_DE} = 3'b000;
        {valid_EM, valid_MW} = 2'b00;
      end
      win_br: begin
        {flush_FD, flush_DE} = 2'b11;
      end
      win_lu: begin
        valid_PC = 1'b0;
        valid_FD = 1'b0;
        flush_DE = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (stall_mem) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_timeout = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_stalls  <= '0;
      perf_br_flushes <= '0;
      perf_mem_freeze <= '0;
    end else begin
      if (win_lu && (perf_lu_stalls != '1))
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (win_br && (perf_br_flushes != '1))
        perf_br_flushes <= perf_br_flushes + 32'd1;
      if (freeze && (perf_mem_freeze != '1))
        perf_mem_freeze <= perf_mem_freeze + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl with an access-level model.
// Directed literal checks pin reset, forwarding, load-use and memory wait.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E;
  logic       dmem_req_M, dmem_ready;
  logic       valid_PC, valid_FD, valid_DE, valid_EM, valid_MW;
  logic       flush_FD, flush_DE, mem_timeout;
  logic [1:0] ForwardA_E, ForwardB_E;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_br_flushes, perf_mem_freeze;
`endif

  pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .MemRead_E(MemRead_E), .RegWrite_M(RegWrite_M),
    .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
    .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .valid_PC(valid_PC), .valid_FD(valid_FD), .valid_DE(valid_DE),
    .valid_EM(valid_EM), .valid_MW(valid_MW),
    .flush_FD(flush_FD), .flush_DE(flush_DE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls)
    , .perf_br_flushes(perf_br_flushes)
    , .perf_mem_freeze(perf_mem_freeze)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] act;
  logic [4:0]  vld;
  assign vld = {valid_PC, valid_FD, valid_DE, valid_EM, valid_MW};
  assign act = {vld, flush_FD, flush_DE, ForwardA_E, ForwardB_E, mem_timeout};

  localparam logic [11:0] RST_OUT = 12'b00000_11_00_00_0;
  localparam logic [11:0] RUN_OUT = 12'b11111_00_00_00_0;

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  // Model: one memory access freezes until ready or TMO freeze cycles.
  bit     m_boot  = 1'b1;
  bit     m_wait  = 1'b0;
  int     m_k     = 0;
  bit     m_pulse = 1'b0;
  longint m_lu = 0, m_br = 0, m_fz = 0;

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu_hit();
    return MemRead_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
  endfunction

  function automatic bit m_frz();
    return m_wait || (dmem_req_M && !dmem_ready);
  endfunction

  function automatic logic [11:0] model_out();
    logic [4:0] v;
    logic [1:0] f;
    logic [3:0] fw;
    if (!rst) return RST_OUT;
    fw = {mfwd(Rs1_E), mfwd(Rs2_E)};
    if (m_boot) begin
      v = 5'b00000; f = 2'b11;
    end else if (m_frz()) begin
      v = 5'b00000; f = 2'b00;
    end else if (PCSrc_E) begin
      v = 5'b11111; f = 2'b11;
    end else if (m_lu_hit()) begin
      v = 5'b00111; f = 2'b01;
    end else begin
      v = 5'b11111; f = 2'b00;
    end
    return {v, f, fw, m_pulse};
  endfunction

  always @(posedge clk) begin
    int k;
    if (!rst) begin
      m_boot = 1; m_wait = 0; m_k = 0; m_pulse = 0;
      m_lu = 0; m_br = 0; m_fz = 0;
    end else if (m_boot) begin
      m_boot = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_frz()) begin
        m_fz++;
        k = m_wait ? m_k + 1 : 1;
        if (m_wait && dmem_ready) begin
          m_wait = 0; m_k = 0;
        end else if (k >= TMO) begin
          m_wait = 0; m_k = 0; m_pulse = 1;
        end else begin
          m_wait = 1; m_k = k;
        end
      end else if (PCSrc_E) begin
        m_br++;
      end else if (m_lu_hit()) begin
        m_lu++;
      end
    end
  end

  always @(negedge clk) begin
    chk("outs", 32'(act), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu", perf_lu_stalls, 32'(m_lu));
    chk("perf_br", perf_br_flushes, 32'(m_br));
    chk("perf_fz", perf_mem_freeze, 32'(m_fz));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E} = '0;
    {Rd_E, Rd_M, Rd_W} = '0;
    {MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E} = '0;
    {dmem_req_M, dmem_ready} = '0;
  endtask

  initial begin
    clr();
    tick(); #3 chk("reset", 32'(act), 32'(RST_OUT));
    tick(); tick();
    rst = 1'b1;
    #3 chk("boot", 32'(act), 32'(RST_OUT));
    tick(); #3 chk("run", 32'(act), 32'(RUN_OUT));

    tick();
    Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
    #3 chk("fwdA_M", 32'(ForwardA_E), 32'd2);
    tick(); RegWrite_M = 0;
    #3 chk("fwdA_W", 32'(ForwardA_E), 32'd1);
    tick(); Rd_W = 0;
    #3 chk("fwdA_none", 32'(ForwardA_E), 32'd0);

    tick(); clr();
    MemRead_E = 1; Rd_E = 7; Rs2_D = 7;
    #3 chk("lu", 32'({valid_PC, valid_FD, flush_DE, flush_FD}), 32'b0010);
    tick(); MemRead_E = 0;
    #3 chk("lu_end", 32'({valid_PC, valid_FD, flush_DE}), 32'b110);
    tick(); MemRead_E = 1; PCSrc_E = 1;
    #3 chk("br_lu", 32'({valid_PC, flush_FD, flush_DE}), 32'b111);

    tick(); clr();
    dmem_req_M = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1;
      #3 chk("mw_frz", 32'(vld), 32'd0);
      tick();
    end
    dmem_req_M = 0; dmem_ready = 0;
    #3 chk("mw_rel", 32'(vld), 32'h1f);
    chk("mw_tmo", 32'(mem_timeout), 32'd0);

    tick(); dmem_req_M = 1;
    for (int i = 0; i < 4; i++) begin
      #3 chk("wd_frz", 32'(vld), 32'd0);
      tick();
    end
    dmem_req_M = 0;
    #3 chk("wd_rel", 32'(vld), 32'h1f);
    chk("wd_tmo", 32'(mem_timeout), 32'd1);
    tick(); #3 chk("wd_tmo_end", 32'(mem_timeout), 32'd0);

    tick(); dmem_req_M = 1;
    tick(); tick();
    #1 rst = 1'b0;
    #1 chk("async", 32'(act), 32'(RST_OUT));
    tick(); tick();
    dmem_req_M = 0; rst = 1'b1;
    #3 chk("boot2", 32'(act), 32'(RST_OUT));
    tick(); #3 chk("run2", 32'(act), 32'(RUN_OUT));
    tick(); dmem_req_M = 1;
    repeat (4) tick();
    dmem_req_M = 0;
    #3 chk("restart_tmo", 32'(mem_timeout), 32'd1);

    repeat (3000) begin
      tick();
      rst        = ($urandom_range(0, 199) != 0);
      Rs1_D      = 5'($urandom_range(0, 3));
      Rs2_D      = 5'($urandom_range(0, 3));
      Rs1_E      = 5'($urandom_range(0, 3));
      Rs2_E      = 5'($urandom_range(0, 3));
      Rd_E       = 5'($urandom_range(0, 3));
      Rd_M       = 5'($urandom_range(0, 3));
      Rd_W       = 5'($urandom_range(0, 3));
      MemRead_E  = ($urandom_range(0, 2) == 0);
      RegWrite_M = $urandom_range(0, 1) == 1;
      RegWrite_W = $urandom_range(0, 1) == 1;
      PCSrc_E    = ($urandom_range(0, 5) == 0);
      dmem_req_M = ($urandom_range(0, 9) < 3);
      dmem_ready = ($urandom_range(0, 9) < 4);
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
